// File: rtl/unsigned_16by8_seq_divider_if.sv
// Valid/ready operand and result bundle for the sequential 16-by-8 unsigned divider.
// The divider uses the slave modport; the producer/consumer uses the master modport.
interface unsigned_16by8_seq_divider_if #(
  parameter int unsigned WIDTH_N = 16,
  parameter int unsigned WIDTH_D = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_N-1:0] z;
  logic [WIDTH_D-1:0] y;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_N-1:0] q;
  logic [WIDTH_D-1:0] r;
  logic               ovf;
  logic               dbz;

  modport master (
    output in_valid,
    input  in_ready,
    output z,
    output y,
    input  out_valid,
    output out_ready,
    input  q,
    input  r,
    input  ovf,
    input  dbz
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  z,
    input  y,
    output out_valid,
    input  out_ready,
    output q,
    output r,
    output ovf,
    output dbz
  );
endinterface

// File: rtl/unsigned_16by8_seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle, MSB first.
// Optional DIV_EARLY_EXIT_EN skips the leading-zero bits of the dividend.
module unsigned_16by8_seq_divider #(
  parameter int unsigned WIDTH_N = 16,
  parameter int unsigned WIDTH_D = 8
) (
  input logic                           clk_i,
  input logic                           rst_i,
  unsigned_16by8_seq_divider_if.slave   bus_io
);

  localparam int unsigned      CntW   = $clog2(WIDTH_N);
  localparam logic [CntW-1:0]  CntMax = CntW'(WIDTH_N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q;
  logic [WIDTH_N-1:0] z_q;
  logic [WIDTH_D-1:0] y_q;
  logic [WIDTH_D-1:0] pr_q;
  logic [WIDTH_N-1:0] quo_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH_N-1:0] q_q;
  logic [WIDTH_D-1:0] r_q;
  logic               ovf_q;
  logic               dbz_q;
  logic               in_ready_q;
  logic               out_valid_q;

  // One restoring step on the (WIDTH_D+1)-bit shifted partial remainder.
  logic [WIDTH_D:0]   pr_shift;
  logic [WIDTH_D:0]   pr_sub;
  logic               q_bit;
  logic [WIDTH_D-1:0] pr_next;
  logic [WIDTH_N-1:0] quo_next;

  always_comb begin
    pr_shift = {pr_q, z_q[cnt_q]};
    pr_sub   = pr_shift - {1'b0, y_q};
    // pr_shift < 2*y, so the difference lies in (-y, y): its sign bit is the borrow.
    q_bit    = ~pr_sub[WIDTH_D];
    pr_next  = q_bit ? pr_sub[WIDTH_D-1:0] : pr_shift[WIDTH_D-1:0];
    quo_next = {quo_q[WIDTH_N-2:0], q_bit};
  end

  logic [CntW-1:0] start_cnt;
  logic            z_zero;

`ifdef DIV_EARLY_EXIT_EN
  always_comb begin
    start_cnt = '0;
    for (int unsigned i = 0; i < WIDTH_N; i++) begin
      if (bus_io.z[i]) begin
        start_cnt = CntW'(i);
      end
    end
    z_zero = (bus_io.z == '0);
  end
`else
  assign start_cnt = CntMax;
  assign z_zero    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      z_q         <= '0;
      y_q         <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.in_valid && in_ready_q) begin
            z_q        <= bus_io.z;
            y_q        <= bus_io.y;
            pr_q       <= '0;
            quo_q      <= '0;
            cnt_q      <= start_cnt;
            in_ready_q <= 1'b0;
            if (bus_io.y == '0) begin
              state_q <= StDone;
              q_q     <= '1;
              r_q     <= bus_io.z[WIDTH_D-1:0];
              ovf_q   <= 1'b1;
              dbz_q   <= 1'b1;
            end else if (z_zero) begin
              state_q <= StDone;
              q_q     <= '0;
              r_q     <= '0;
              ovf_q   <= 1'b0;
              dbz_q   <= 1'b0;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          pr_q  <= pr_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_q <= StDone;
            q_q     <= quo_next;
            r_q     <= pr_next;
            ovf_q   <= |quo_next[WIDTH_N-1:WIDTH_D];
            dbz_q   <= 1'b0;
          end
        end
        StDone: begin
          // First DONE cycle only raises out_valid; results were loaded on entry.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.q         = q_q;
  assign bus_io.r         = r_q;
  assign bus_io.ovf       = ovf_q;
  assign bus_io.dbz       = dbz_q;

endmodule

// File: tb/tb_unsigned_16by8_seq_divider.sv
// Self-checking bench for unsigned_16by8_seq_divider: directed cases plus random operands
// against an arithmetic reference model (honours DIV_EARLY_EXIT_EN for expected latency).
module tb_unsigned_16by8_seq_divider;

  localparam int unsigned WN = 16;
  localparam int unsigned WD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  unsigned_16by8_seq_divider_if #(.WIDTH_N(WN), .WIDTH_D(WD)) bus ();

  unsigned_16by8_seq_divider #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned exp_latency(input int unsigned z, input int unsigned y);
    int unsigned n;
    int unsigned v;
    if (y == 0) return 1;
    n = 0;
    v = z;
`ifdef DIV_EARLY_EXIT_EN
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
`else
    n = WN;
`endif
    return n + 1;
  endfunction

  task automatic issue(input int unsigned z, input int unsigned y);
    bus.z        = z[WN-1:0];
    bus.y        = y[WD-1:0];
    bus.in_valid = 1'b1;
    check_eq("in_ready_before_accept", {31'd0, bus.in_ready}, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (bus.out_valid === 1'b1) begin
          seen = 1'b1;
          lat  = k;
        end
      end
    end
  endtask

  task automatic check_result(input string tag, input int unsigned z, input int unsigned y,
                              input int unsigned lat);
    int unsigned eq, er, eovf, edbz;
    if (y == 0) begin
      eq   = 32'hFFFF;
      er   = z & 32'hFF;
      eovf = 1;
      edbz = 1;
    end else begin
      eq   = z / y;
      er   = z % y;
      eovf = (eq > 255) ? 1 : 0;
      edbz = 0;
    end
    check_eq({tag, "_lat"}, lat, exp_latency(z, y));
    check_eq({tag, "_q"},   {16'd0, bus.q}, eq);
    check_eq({tag, "_r"},   {24'd0, bus.r}, er);
    check_eq({tag, "_ovf"}, {31'd0, bus.ovf}, eovf);
    check_eq({tag, "_dbz"}, {31'd0, bus.dbz}, edbz);
  endtask

  task automatic run_op(input string tag, input int unsigned z, input int unsigned y);
    int unsigned lat;
    bus.out_ready = 1'b1;
    issue(z, y);
    wait_valid(lat);
    check_result(tag, z, y, lat);
    @(posedge clk);
    #1;
    check_eq({tag, "_idle_in_ready"}, {31'd0, bus.in_ready}, 1);
    check_eq({tag, "_idle_out_valid"}, {31'd0, bus.out_valid}, 0);
  endtask

  initial begin
    int unsigned lat;
    int unsigned rz, ry;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.z         = '0;
    bus.y         = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  {31'd0, bus.in_ready}, 1);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check_eq("rst_q",         {16'd0, bus.q}, 0);
    check_eq("rst_r",         {24'd0, bus.r}, 0);
    check_eq("rst_ovf",       {31'd0, bus.ovf}, 0);
    check_eq("rst_dbz",       {31'd0, bus.dbz}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("sq123",    15129, 123);
    run_op("max_by1",  65535, 1);
    run_op("max_by255", 65535, 255);
    run_op("k1000_by7", 1000, 7);
    run_op("dbz",      16'h1234, 0);
    run_op("small_5_2", 5, 2);
    run_op("zero_9",   0, 9);

    // Result held under backpressure; new operands must be ignored.
    bus.out_ready = 1'b0;
    issue(1000, 7);
    wait_valid(lat);
    check_result("bp", 1000, 7, lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.z        = 16'h5555;
      bus.y        = 8'd3;
      @(posedge clk);
      #1;
      check_eq("bp_out_valid", {31'd0, bus.out_valid}, 1);
      check_eq("bp_in_ready",  {31'd0, bus.in_ready}, 0);
      check_eq("bp_q",         {16'd0, bus.q}, 142);
      check_eq("bp_r",         {24'd0, bus.r}, 6);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release_out_valid", {31'd0, bus.out_valid}, 0);
    check_eq("bp_release_in_ready",  {31'd0, bus.in_ready}, 1);

    // Reset in the middle of a calculation discards it.
    issue(40000, 3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", {31'd0, bus.out_valid}, 0);
    check_eq("midrst_in_ready",  {31'd0, bus.in_ready}, 1);
    check_eq("midrst_q",         {16'd0, bus.q}, 0);
    check_eq("midrst_r",         {24'd0, bus.r}, 0);
    rst = 1'b0;
    run_op("after_rst", 200, 10);

    for (int i = 0; i < 2000; i++) begin
      rz = $urandom_range(0, 65535) >> $urandom_range(0, 15);
      ry = $urandom_range(1, 255);
      run_op("rand", rz, ry);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
